clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank_pkg.sv | 9 +
 rtl/clk_div_chan.sv | 41 ++++
 rtl/clk_div_bank.sv | 73 +++++++
 tb/tb_clk_div_bank.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_bank_pkg.sv
// clk_div_bank_pkg: FSM states, minimum divide ratio and channel start-value helper.
package clk_div_bank_pkg;
  typedef enum logic [1:0] {IDLE, ALIGN, SETTLE, LOCKED} state_e;
  localparam int MIN_DIV = 2;
  localparam int FN_W = 32;
  function automatic logic [FN_W-1:0] start_val(input logic [FN_W-1:0] d, input logic [FN_W-1:0] p);
    return (p != '0 && p < d) ? d - p : '0;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divided-clock channel with ratio clamp, duty compare and live enable.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             en_i,
  output logic             out_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, d, half, start, nxt, c;
  logic out_q, out_d, en_q, go, restart;
  assign d = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
  assign half = (d >> 1) + DIV_W'(d[0]);
  assign start = DIV_W'(start_val(FN_W'(d), FN_W'(phase_i)));
  // A freshly re-enabled channel restarts from its start value, like an ALIGN load.
  always_comb begin
    go = load_i || run_i;
    restart = load_i || !en_q;
    nxt = (cnt_q == d - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
    c = restart ? start : nxt;
    cnt_d = !go ? cnt_q : en_i ? c : start;
    out_d = go && en_i && (c < half);
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      en_q <= en_i;
    end
  assign out_o = out_q;
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of aligned divided clocks with configuration FSM and lock indication.
// Per-channel phase offsets are enabled by defining CLK_DIV_BANK_PHASE_EN.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                        refclk,
  input  logic                        rst_n,
  input  logic [NUM_CLOCKS*DIV_W-1:0] div_ratio,
  input  logic [NUM_CLOCKS*DIV_W-1:0] phase,
  input  logic                        cfg_load,
  input  logic [NUM_CLOCKS-1:0]       chan_en,
  output logic [NUM_CLOCKS-1:0]       outclk,
  output logic                        locked,
  output logic                        cfg_busy
);
  localparam int SW = $clog2(LOCK_CYCLES + 1);
  state_e state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [NUM_CLOCKS*DIV_W-1:0] div_q, phase_eff;
  logic load, run;
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      settle_q <= '0;
      div_q <= {NUM_CLOCKS{DIV_W'(MIN_DIV)}};
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      div_q <= cfg_load ? div_ratio : div_q;
    end
  // SETTLE spans LOCK_CYCLES+1 cycles so locked rises LOCK_CYCLES+2 edges after the strobe.
  always_comb begin
    state_d = cfg_load ? ALIGN
            : state_q == IDLE ? IDLE
            : state_q == ALIGN ? SETTLE
            : (state_q == SETTLE && settle_q != SW'(LOCK_CYCLES)) ? SETTLE
            : LOCKED;
    settle_d = (state_q == SETTLE) ? settle_q + SW'(1) : '0;
  end
  always_comb begin
    locked = state_q == LOCKED;
    cfg_busy = state_q == ALIGN || state_q == SETTLE;
    load = state_q == ALIGN && !cfg_load;
    run = (state_q == SETTLE || state_q == LOCKED) && !cfg_load;
  end
`ifdef CLK_DIV_BANK_PHASE_EN
  logic [NUM_CLOCKS*DIV_W-1:0] phase_q;
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) phase_q <= '0;
    else phase_q <= cfg_load ? phase : phase_q;
  assign phase_eff = phase_q;
`else
  logic phase_unused;
  assign phase_unused = ^phase;
  assign phase_eff = '0;
`endif
  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    clk_div_chan #(.DIV_W(DIV_W)) u_chan (
      .refclk (refclk),
      .rst_n  (rst_n),
      .div_i  (div_q[i*DIV_W +: DIV_W]),
      .phase_i(phase_eff[i*DIV_W +: DIV_W]),
      .load_i (load),
      .run_i  (run),
      .en_i   (chan_en[i]),
      .out_o  (outclk[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed table-driven bench for clk_div_bank (4 channels, DIV_W=8, LOCK_CYCLES=64).
module tb_clk_div_bank;
  logic refclk = 1'b0;
  logic rst_n;
  logic [31:0] div_ratio, phase;
  logic cfg_load;
  logic [3:0] chan_en, outclk;
  logic locked, cfg_busy;
  int nvec = 0, nbad = 0, cyc = 0, t0 = 0;

  typedef struct {
    string name;
    logic [31:0] div;
    logic [31:0] per;
    logic [31:0] hi;
  } vec_t;
  vec_t vecs[3];

  clk_div_bank #(.NUM_CLOCKS(4), .DIV_W(8), .LOCK_CYCLES(64)) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .div_ratio(div_ratio),
    .phase    (phase),
    .cfg_load (cfg_load),
    .chan_en  (chan_en),
    .outclk   (outclk),
    .locked   (locked),
    .cfg_busy (cfg_busy)
  );

  always #5 refclk = ~refclk;

  task automatic step;
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_out(input int per, input int hi, input int t);
    return (t % per) < hi;
  endfunction

  task automatic strobe(input logic [31:0] d);
    div_ratio = d;
    cfg_load = 1'b1;
    step;
    cfg_load = 1'b0;
  endtask

  task automatic wait_lock(input int c0, input string name);
    int c = c0;
    while (locked !== 1'b1 && c < 300) begin
      step;
      c++;
    end
    check(name, c, 66);
  endtask

  task automatic run_wave(input vec_t v, input int n);
    int bad[4];
    bad = '{default: 0};
    t0 = cyc;
    for (int t = 0; t < n; t++) begin
      for (int ch = 0; ch < 4; ch++)
        if (outclk[ch] !== exp_out(int'(v.per[ch*8 +: 8]), int'(v.hi[ch*8 +: 8]), t)) bad[ch]++;
      step;
    end
    for (int ch = 0; ch < 4; ch++) check($sformatf("%s_wave_ch%0d_bad_cycles", v.name, ch), bad[ch], 0);
  endtask

  task automatic others_bad(input vec_t v, inout int badx);
    for (int ch = 0; ch < 4; ch++)
      if (ch != 2 && outclk[ch] !== exp_out(int'(v.per[ch*8 +: 8]), int'(v.hi[ch*8 +: 8]), cyc - t0)) badx++;
  endtask

  initial begin
    int bad, badx, t2;
    vecs[0] = '{"base",  {8'd10, 8'd4, 8'd3, 8'd2}, {8'd10, 8'd4, 8'd3, 8'd2}, {8'd5, 8'd2, 8'd2, 8'd1}};
    vecs[1] = '{"redo6", {8'd10, 8'd4, 8'd3, 8'd6}, {8'd10, 8'd4, 8'd3, 8'd6}, {8'd5, 8'd2, 8'd2, 8'd3}};
    vecs[2] = '{"clamp", {8'd7,  8'd5, 8'd1, 8'd0}, {8'd7,  8'd5, 8'd2, 8'd2}, {8'd4, 8'd3, 8'd1, 8'd1}};
    rst_n = 1'b0;
    cfg_load = 1'b0;
    div_ratio = '0;
    phase = '0;
    chan_en = 4'hF;
    #2;
    check("reset_outclk", outclk, 0);
    check("reset_locked", locked, 0);
    check("reset_busy", cfg_busy, 0);
    step;
    step;
    rst_n = 1'b1;
    repeat (5) step;
    check("idle_outclk", outclk, 0);
    check("idle_busy", cfg_busy, 0);
    check("idle_locked", locked, 0);

    for (int i = 0; i < 3; i++) begin
      strobe(vecs[i].div);
      check({vecs[i].name, "_align_outclk"}, outclk, 0);
      check({vecs[i].name, "_align_busy"}, cfg_busy, 1);
      check({vecs[i].name, "_align_locked"}, locked, 0);
      step;
      run_wave(vecs[i], 60);
      wait_lock(61, {vecs[i].name, "_lock_latency"});
      check({vecs[i].name, "_locked_busy"}, cfg_busy, 0);
      if (i == 0) begin
        bad = 0;
        badx = 0;
        chan_en[2] = 1'b0;
        step;
        check("en_off_low", outclk[2], 0);
        repeat (6) begin
          if (outclk[2] !== 1'b0) bad++;
          others_bad(vecs[0], badx);
          step;
        end
        check("en_off_hold_bad_cycles", bad, 0);
        check("en_off_locked", locked, 1);
        chan_en[2] = 1'b1;
        step;
        t2 = cyc;
        check("en_restart_high", outclk[2], 1);
        bad = 0;
        repeat (12) begin
          if (outclk[2] !== exp_out(4, 2, cyc - t2)) bad++;
          others_bad(vecs[0], badx);
          step;
        end
        check("en_resume_bad_cycles", bad, 0);
        check("en_others_bad_cycles", badx, 0);
        check("en_on_locked", locked, 1);
      end
    end

    strobe(vecs[0].div);
    repeat (9) step;
    strobe(vecs[0].div);
    wait_lock(0, "double_strobe_latency");

    strobe(vecs[0].div);
    repeat (10) step;
    check("settle_busy_before_rst", cfg_busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_outclk", outclk, 0);
    check("midrst_locked", locked, 0);
    check("midrst_busy", cfg_busy, 0);
    step;
    rst_n = 1'b1;
    repeat (5) step;
    check("postrst_idle_busy", cfg_busy, 0);
    check("postrst_idle_outclk", outclk, 0);

`ifdef CLK_DIV_BANK_PHASE_EN
    phase = {8'd0, 8'd8, 8'd3, 8'd0};
    strobe({8'd8, 8'd8, 8'd8, 8'd8});
    step;
    bad = 0;
    badx = 0;
    t2 = 0;
    for (int t = 0; t < 40; t++) begin
      if (outclk[0] !== exp_out(8, 4, t)) bad++;
      if (outclk[1] !== exp_out(8, 4, t + 5)) badx++;
      if (outclk[2] !== outclk[0]) t2++;
      step;
    end
    check("phase_ch0_bad_cycles", bad, 0);
    check("phase_ch1_lag3_bad_cycles", badx, 0);
    check("phase_ch2_aligned_bad_cycles", t2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
